// File: rtl/mod_keypad_scan_if.sv
// Keypad-side signal bundle: column strobes out, row sense in, decoded key out.
// Latency: none, pure wiring.
// Backpressure: none; o_key_valid is a one-cycle strobe with no ready.
interface mod_keypad_scan_if;
    logic [3:0] o_col_nSel;
    logic [3:0] i_row_n;
    logic [3:0] o_key;
    logic       o_key_valid;
    logic       o_key_held;

    // Scanner side: drives columns and key results, senses rows.
    modport master (
        output o_col_nSel,
        output o_key,
        output o_key_valid,
        output o_key_held,
        input  i_row_n
    );

    // Board/consumer side: senses columns and key results, drives rows.
    modport slave (
        input  o_col_nSel,
        input  o_key,
        input  o_key_valid,
        input  o_key_held,
        output i_row_n
    );
endinterface

// File: rtl/mod_keypad_scan.sv
// Scanned 4x4 hex keypad receiver with frame-level debounce and multi-key rejection.
// Latency: key accepted on the edge after the frame-ending tick of the DEBOUNCE_SCANS-th agreeing frame.
// Backpressure: none; o_key_valid pulses for one cycle and o_key holds until the next acceptance.
module mod_keypad_scan #(
    parameter int SCAN_DIV_BITS  = 15,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mod_keypad_scan_if.master kp
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_HELD,
        S_RELEASE
    } state_t;

    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    // Row code for (row, col); row 3 reads 0 F E D left to right.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0]               row_s1, row_s2;
    logic [SCAN_DIV_BITS-1:0] div_q;
    logic                     tick;
    logic [1:0]               col_q;

    // Accumulator count saturates at 2: anything beyond one key is rejected alike.
    logic [1:0] acc_cnt_q;
    logic [3:0] acc_code_q;
    logic [1:0] col_hits;
    logic [3:0] col_code;
    logic [2:0] hit_sum;
    logic [1:0] tot_hits;
    logic [3:0] frame_code;
    logic       frame_end;
    logic       frame_key;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0] cand_q, cand_d;
    logic [3:0] key_q, key_d;
    logic       valid_q, valid_d;
    logic       held_q, held_d;
    logic       cand_match;

    // Two-flop synchronizer for the asynchronous row lines; idles high like the pull-ups.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= kp.i_row_n;
            row_s2 <= row_s1;
        end
    end

    assign tick      = &div_q;
    assign frame_end = tick && (col_q == 2'd3);

    // Free-running divider and column pointer; the column only advances on tick.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q <= '0;
            col_q <= 2'd0;
        end else begin
            div_q <= div_q + 1'b1;
            if (tick) begin
                col_q <= col_q + 2'd1;
            end
        end
    end

    assign kp.o_col_nSel = ~(4'b0001 << col_q);

    // Decode the current column's rows: count of keys down (saturating) and last code seen.
    always_comb begin
        col_hits = 2'd0;
        col_code = 4'h0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2[r]) begin
                col_code = key_code(2'(r), col_q);
                if (col_hits != 2'd2) begin
                    col_hits = col_hits + 2'd1;
                end
            end
        end
    end

    assign hit_sum    = {1'b0, acc_cnt_q} + {1'b0, col_hits};
    assign tot_hits   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    assign frame_code = (col_hits != 2'd0) ? col_code : acc_code_q;
    assign frame_key  = (tot_hits == 2'd1);

    // Per-frame accumulation of sampled keys; cleared once the frame result is consumed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'h0;
        end else if (frame_end) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'h0;
        end else if (tick) begin
            acc_cnt_q  <= tot_hits;
            acc_code_q <= frame_code;
        end
    end

    // Debounce state and registered key outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            cand_q  <= 4'h0;
            key_q   <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign cnt_inc    = cnt_q + 4'd1;
    assign cand_match = frame_key && (frame_code == cand_q);

    // Debounce transitions, evaluated only on the frame-ending tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        key_d   = key_q;
        valid_d = 1'b0;
        held_d  = held_q;
        if (frame_end) begin
            case (state_q)
                S_IDLE: begin
                    if (frame_key) begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                        if (DEB == 4'd1) begin
                            state_d = S_HELD;
                            key_d   = frame_code;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                        end else begin
                            state_d = S_PRESS;
                        end
                    end
                end
                S_PRESS: begin
                    if (cand_match) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB) begin
                            state_d = S_HELD;
                            key_d   = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                        end
                    end else if (frame_key) begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                S_HELD: begin
                    if (!cand_match) begin
                        if (DEB == 4'd1) begin
                            state_d = S_IDLE;
                            cnt_d   = 4'd0;
                            held_d  = 1'b0;
                        end else begin
                            state_d = S_RELEASE;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                default: begin
                    // Release in progress: the same key coming back cancels it silently.
                    if (cand_match) begin
                        state_d = S_HELD;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB) begin
                            state_d = S_IDLE;
                            cnt_d   = 4'd0;
                            held_d  = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign kp.o_key       = key_q;
    assign kp.o_key_valid = valid_q;
    assign kp.o_key_held  = held_q;

endmodule
